// File: rtl/bids22_pkg.sv
// Shared types for the bids22 host sequencer: core opcodes, sequencer error codes, FSM states, config bundle.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package bids22_pkg;

    typedef enum logic [3:0] {
        OP_NOOP      = 4'd0,
        OP_UNLOCK    = 4'd1,
        OP_LOCK      = 4'd2,
        OP_LOADX     = 4'd3,
        OP_LOADY     = 4'd4,
        OP_LOADZ     = 4'd5,
        OP_SETMASK   = 4'd6,
        OP_SETTIMER  = 4'd7,
        OP_BIDCHARGE = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        SERR_OK      = 2'd0,
        SERR_CORE    = 2'd1,
        SERR_TIMEOUT = 2'd2,
        SERR_NOWIN   = 2'd3
    } seq_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNLOCK,
        ST_LOAD,
        ST_LOCK,
        ST_RUN,
        ST_RESULT,
        ST_DONE
    } seq_state_e;

    // Index of the last configuration opcode (BidCharge) within the LOAD burst.
    localparam logic [2:0] LOAD_LAST = 3'd5;

    // Round configuration captured when a start request is accepted.
    typedef struct packed {
        logic [31:0] x_bal;
        logic [31:0] y_bal;
        logic [31:0] z_bal;
        logic [2:0]  mask;
        logic [31:0] timer;
        logic [31:0] cost;
        logic [31:0] key;
    } cfg_t;

    // Opcode issued at a given position of the LOAD burst.
    function automatic op_e load_op(input logic [2:0] idx);
        case (idx)
            3'd0:    load_op = OP_LOADX;
            3'd1:    load_op = OP_LOADY;
            3'd2:    load_op = OP_LOADZ;
            3'd3:    load_op = OP_SETMASK;
            3'd4:    load_op = OP_SETTIMER;
            3'd5:    load_op = OP_BIDCHARGE;
            default: load_op = OP_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Loadable down-counter with zero flag, shared between the RUN length and the ready/result timeouts.
// Latency: load/decrement take effect on the next clock; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module seq_timeout_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bid_round_sequencer.sv
// Runs one bids22 auction round per start pulse: config opcodes, Lock, C_start burst, result capture.
// Latency: LoadX one cycle after start, Lock at +7, C_start for max(round_len,1) cycles (ready=1 throughout).
// Backpressure: opcodes hold while ready=0; WAIT_TIMEOUT idle cycles abort. SEQ_AUTO_UNLOCK_EN adds a trailing Unlock.
module bid_round_sequencer
    import bids22_pkg::*;
#(
    parameter int ROUND_W      = 16,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        cfg_x_bal,
    input  logic [31:0]        cfg_y_bal,
    input  logic [31:0]        cfg_z_bal,
    input  logic [2:0]         cfg_mask,
    input  logic [31:0]        cfg_timer,
    input  logic [31:0]        cfg_cost,
    input  logic [31:0]        cfg_key,
    input  logic [ROUND_W-1:0] round_len,
    output logic [3:0]         C_op,
    output logic [31:0]        C_data,
    output logic               C_start,
    input  logic               ready,
    input  logic               roundOver,
    input  logic [2:0]         err,
    input  logic [31:0]        maxBid,
    input  logic               X_win,
    input  logic               Y_win,
    input  logic               Z_win,
    output logic               busy,
    output logic               done,
    output logic [31:0]        res_max,
    output logic [2:0]         res_win,
    output logic [1:0]         seq_err
);

    // Counter must hold both round_len-1 and WAIT_TIMEOUT-1.
    localparam int TO_W  = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam int CNT_W = (ROUND_W > TO_W) ? ROUND_W : TO_W;
    localparam logic [CNT_W-1:0] T_RELOAD = CNT_W'(WAIT_TIMEOUT - 1);

    seq_state_e         state_q, state_d;
    cfg_t               cfg_q;
    logic [ROUND_W-1:0] len_q;
    logic [ROUND_W-1:0] len_m1;
    logic [2:0]         load_idx_q, load_idx_d;
    logic [31:0]        res_max_q, res_max_d;
    logic [2:0]         res_win_q, res_win_d;
    seq_err_e           seq_err_q, seq_err_d;
    op_e                op;
    logic [31:0]        op_data;
    logic [31:0]        load_data;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               start_acc;
`ifndef SEQ_AUTO_UNLOCK_EN
    logic               locked_q, locked_d;
`endif

    assign start_acc = (state_q == ST_IDLE) && start;
    assign len_m1    = (len_q == '0) ? '0 : (len_q - ROUND_W'(1));

    seq_timeout_ctr #(.W(CNT_W)) u_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Operand for the current position of the LOAD burst.
    always_comb begin
        load_data = '0;
        case (load_idx_q)
            3'd0:    load_data = cfg_q.x_bal;
            3'd1:    load_data = cfg_q.y_bal;
            3'd2:    load_data = cfg_q.z_bal;
            3'd3:    load_data = {29'd0, cfg_q.mask};
            3'd4:    load_data = cfg_q.timer;
            3'd5:    load_data = cfg_q.cost;
            default: load_data = '0;
        endcase
    end

    // Next-state, counter control and core-facing outputs.
    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        res_max_d    = res_max_q;
        res_win_d    = res_win_q;
        seq_err_d    = seq_err_q;
`ifndef SEQ_AUTO_UNLOCK_EN
        locked_d     = locked_q;
`endif
        cnt_load     = 1'b0;
        cnt_load_val = T_RELOAD;
        cnt_dec      = 1'b0;
        op           = OP_NOOP;
        op_data      = '0;
        C_start      = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    res_max_d  = '0;
                    res_win_d  = '0;
                    seq_err_d  = SERR_OK;
                    load_idx_d = '0;
                    cnt_load   = 1'b1;
`ifdef SEQ_AUTO_UNLOCK_EN
                    state_d    = ST_LOAD;
`else
                    // A core left locked by the previous round must be reopened first.
                    state_d    = locked_q ? ST_UNLOCK : ST_LOAD;
`endif
                end
            end
            ST_UNLOCK: begin
                op      = OP_UNLOCK;
                op_data = cfg_q.key;
                if (ready) begin
`ifdef SEQ_AUTO_UNLOCK_EN
                    state_d  = ST_DONE;
`else
                    locked_d = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                op      = load_op(load_idx_q);
                op_data = load_data;
                if (ready) begin
                    if (err != 3'd0) begin
                        seq_err_d = SERR_CORE;
                        state_d   = ST_DONE;
                    end else begin
                        cnt_load = 1'b1;
                        if (load_idx_q == LOAD_LAST) begin
                            state_d = ST_LOCK;
                        end else begin
                            load_idx_d = load_idx_q + 3'd1;
                        end
                    end
                end
            end
            ST_LOCK: begin
                op      = OP_LOCK;
                op_data = cfg_q.key;
                if (ready) begin
                    if (err != 3'd0) begin
                        seq_err_d = SERR_CORE;
                        state_d   = ST_DONE;
                    end else begin
`ifndef SEQ_AUTO_UNLOCK_EN
                        locked_d     = 1'b1;
`endif
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(len_m1);
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                C_start = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    state_d  = ST_RESULT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESULT: begin
                if (roundOver) begin
                    res_max_d = maxBid;
                    res_win_d = {Z_win, Y_win, X_win};
                    if ({Z_win, Y_win, X_win} == 3'd0) begin
                        seq_err_d = SERR_NOWIN;
                    end
`ifdef SEQ_AUTO_UNLOCK_EN
                    cnt_load = 1'b1;
                    state_d  = ST_UNLOCK;
`else
                    state_d  = ST_DONE;
`endif
                end else if (cnt_zero) begin
                    seq_err_d = SERR_TIMEOUT;
                    state_d   = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any opcode-issuing state stalls on ready=0 and aborts after WAIT_TIMEOUT idle cycles.
        if (((state_q == ST_UNLOCK) || (state_q == ST_LOAD) || (state_q == ST_LOCK)) && !ready) begin
            if (cnt_zero) begin
                seq_err_d = SERR_TIMEOUT;
                state_d   = ST_DONE;
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    // State, captured config and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            len_q      <= '0;
            load_idx_q <= '0;
            res_max_q  <= '0;
            res_win_q  <= '0;
            seq_err_q  <= SERR_OK;
`ifndef SEQ_AUTO_UNLOCK_EN
            locked_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            res_max_q  <= res_max_d;
            res_win_q  <= res_win_d;
            seq_err_q  <= seq_err_d;
`ifndef SEQ_AUTO_UNLOCK_EN
            locked_q   <= locked_d;
`endif
            if (start_acc) begin
                cfg_q.x_bal <= cfg_x_bal;
                cfg_q.y_bal <= cfg_y_bal;
                cfg_q.z_bal <= cfg_z_bal;
                cfg_q.mask  <= cfg_mask;
                cfg_q.timer <= cfg_timer;
                cfg_q.cost  <= cfg_cost;
                cfg_q.key   <= cfg_key;
                len_q       <= round_len;
            end
        end
    end

    assign C_op    = op;
    assign C_data  = op_data;
    assign busy    = (state_q != ST_IDLE);
    assign res_max = res_max_q;
    assign res_win = res_win_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_bid_round_sequencer.sv
// Self-checking bench: builds each round's expected cycle-by-cycle waveform from the opcode/stall/timeout rules.
// Latency: n/a.
// Backpressure: ready is randomised or scripted per round; start is pulsed while busy.
`timescale 1ns/1ps
module tb_bid_round_sequencer;

    localparam int ROUND_W = 16;
    localparam int T       = 64;
    localparam int MAXC    = 600;
`ifdef SEQ_AUTO_UNLOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        cfg_x_bal = '0, cfg_y_bal = '0, cfg_z_bal = '0;
    logic [2:0]         cfg_mask = '0;
    logic [31:0]        cfg_timer = '0, cfg_cost = '0, cfg_key = '0;
    logic [ROUND_W-1:0] round_len = '0;
    logic [3:0]         C_op;
    logic [31:0]        C_data;
    logic               C_start;
    logic               ready = 1'b0, roundOver = 1'b0;
    logic [2:0]         err = '0;
    logic [31:0]        maxBid = '0;
    logic               X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
    logic               busy, done;
    logic [31:0]        res_max;
    logic [2:0]         res_win;
    logic [1:0]         seq_err;

    always #5 clk = ~clk;

    bid_round_sequencer #(.ROUND_W(ROUND_W), .WAIT_TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_x_bal(cfg_x_bal), .cfg_y_bal(cfg_y_bal), .cfg_z_bal(cfg_z_bal),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost), .cfg_key(cfg_key),
        .round_len(round_len), .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .ready(ready), .roundOver(roundOver), .err(err), .maxBid(maxBid),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
        .busy(busy), .done(done), .res_max(res_max), .res_win(res_win), .seq_err(seq_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected waveform and stimulus per cycle of a round (cycle 1 = first cycle after start is taken).
    logic [3:0]  e_op   [MAXC];
    logic [31:0] e_data [MAXC];
    bit          e_cs   [MAXC];
    bit          e_busy [MAXC];
    bit          e_done [MAXC];
    bit          s_rdy  [MAXC];
    bit          s_ro   [MAXC];
    bit          s_start[MAXC];
    logic [2:0]  s_err  [MAXC];
    logic [31:0] s_max  [MAXC];
    logic [2:0]  s_win  [MAXC];
    int          done_c;
    logic [31:0] x_max;
    logic [2:0]  x_win;
    logic [1:0]  x_serr;
    bit          m_locked = 1'b0;
    int          stalls_z;

    // Round parameters.
    logic [31:0] r_x, r_y, r_z, r_timer, r_cost, r_key, r_ro_max;
    logic [2:0]  r_mask, r_err_val, r_ro_win;
    logic [15:0] r_len;
    int          r_mode, r_err_pos, r_ro_delay;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_round(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                             input logic [2:0] mask, input logic [31:0] timer, input logic [31:0] cost,
                             input logic [31:0] key, input logic [15:0] len, input int mode,
                             input int err_pos, input logic [2:0] err_val, input int ro_delay,
                             input logic [31:0] ro_max, input logic [2:0] ro_win);
        r_x = x; r_y = y; r_z = z; r_mask = mask; r_timer = timer; r_cost = cost; r_key = key;
        r_len = len; r_mode = mode; r_err_pos = err_pos; r_err_val = err_val;
        r_ro_delay = ro_delay; r_ro_max = ro_max; r_ro_win = ro_win;
    endtask

    // One opcode presented until ready=1 (or T idle cycles); idx>=0 marks a LOAD/LOCK opcode.
    task automatic issue_op(input logic [3:0] op, input logic [31:0] dat, input int idx,
                            inout int c, output bit ok);
        int zeros;
        bit r;
        zeros = 0;
        ok = 1'b0;
        while (c < MAXC - 2) begin
            e_op[c] = op; e_data[c] = dat; e_busy[c] = 1'b1;
            case (r_mode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 3) != 0);
                2: begin r = !(op == 4'd5 && stalls_z < 3); if (!r) stalls_z++; end
                default: r = 1'b0;
            endcase
            s_rdy[c] = r;
            if (r) begin
                s_err[c] = (idx >= 0 && idx == r_err_pos) ? r_err_val : 3'd0;
                c++;
                if (s_err[c-1] != 3'd0) begin
                    x_serr = 2'd1;
                end else begin
                    ok = 1'b1;
                    if (op == 4'd1) m_locked = 1'b0;
                    if (op == 4'd2) m_locked = 1'b1;
                end
                return;
            end
            s_err[c] = 3'($urandom_range(0, 7));
            c++;
            zeros++;
            if (zeros == T) begin
                x_serr = 2'd2;
                return;
            end
        end
    endtask

    task automatic build();
        int c, n;
        bit ok, got;
        logic [31:0] d [7];
        for (int i = 0; i < MAXC; i++) begin
            e_op[i] = '0; e_data[i] = '0; e_cs[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            s_rdy[i] = 1'($urandom_range(0, 1)); s_err[i] = 3'($urandom_range(0, 7));
            s_ro[i] = 0; s_start[i] = 0; s_max[i] = $urandom; s_win[i] = 3'($urandom_range(0, 7));
        end
        d = '{r_x, r_y, r_z, {29'd0, r_mask}, r_timer, r_cost, r_key};
        c = 1; x_max = '0; x_win = '0; x_serr = '0; stalls_z = 0; ok = 1'b1;
        if (!AUTO && m_locked) issue_op(4'd1, r_key, -1, c, ok);
        for (int j = 0; j < 7 && ok; j++) issue_op(4'((j == 6) ? 2 : 3 + j), d[j], j, c, ok);
        if (ok) begin
            n = (r_len == 0) ? 1 : int'(r_len);
            repeat (n) begin e_cs[c] = 1; e_busy[c] = 1; c++; end
            got = 0;
            for (int w = 0; w < T && !got; w++) begin
                e_busy[c] = 1;
                if (w == r_ro_delay) begin
                    s_ro[c] = 1; s_max[c] = r_ro_max; s_win[c] = r_ro_win; got = 1;
                end
                c++;
            end
            if (got) begin
                x_max = r_ro_max; x_win = r_ro_win; x_serr = (r_ro_win == 3'd0) ? 2'd3 : 2'd0;
                if (AUTO) issue_op(4'd1, r_key, -1, c, ok);
            end else begin
                x_serr = 2'd2;
            end
        end
        e_busy[c] = 1; e_done[c] = 1; done_c = c;
        for (int i = 1; i <= done_c; i++) s_start[i] = ($urandom_range(0, 5) == 0);
    endtask

    // Applies the built round; stop_at>0 returns right after checking that cycle.
    task automatic run_round(input int stop_at);
        @(negedge clk);
        chk("idle_busy", busy, 0); chk("idle_op", C_op, 0);
        chk("idle_cstart", C_start, 0); chk("idle_done", done, 0);
        start = 1'b1; cfg_x_bal = r_x; cfg_y_bal = r_y; cfg_z_bal = r_z; cfg_mask = r_mask;
        cfg_timer = r_timer; cfg_cost = r_cost; cfg_key = r_key; round_len = r_len;
        ready = 1'b0; err = '0; roundOver = 1'b0;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            chk($sformatf("op@%0d", c), C_op, e_op[c]);
            chk($sformatf("data@%0d", c), C_data, e_data[c]);
            chk($sformatf("cstart@%0d", c), C_start, e_cs[c]);
            chk($sformatf("busy@%0d", c), busy, e_busy[c]);
            chk($sformatf("done@%0d", c), done, e_done[c]);
            if (c == 1) begin
                chk("res_max_clr", res_max, 0); chk("res_win_clr", res_win, 0); chk("seq_err_clr", seq_err, 0);
            end
            if (c >= done_c) begin
                chk($sformatf("res_max@%0d", c), res_max, x_max);
                chk($sformatf("res_win@%0d", c), res_win, x_win);
                chk($sformatf("seq_err@%0d", c), seq_err, x_serr);
            end
            if (c == stop_at) return;
            start = s_start[c]; ready = s_rdy[c]; err = s_err[c]; roundOver = s_ro[c];
            maxBid = s_max[c]; {Z_win, Y_win, X_win} = s_win[c];
            cfg_x_bal = $urandom; cfg_y_bal = $urandom; cfg_z_bal = $urandom;
            cfg_mask = 3'($urandom_range(0, 7)); cfg_timer = $urandom; cfg_cost = $urandom;
            cfg_key = $urandom; round_len = 16'($urandom_range(0, 9));
        end
    endtask

    initial begin
        int stop_c;
        #3;
        chk("rst_op", C_op, 0); chk("rst_data", C_data, 0); chk("rst_cstart", C_start, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_res_max", res_max, 0);
        chk("rst_res_win", res_win, 0); chk("rst_seq_err", seq_err, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Nominal round.
        set_round(100, 200, 300, 3'd7, 32'd1000, 1, 32'h0F0F0F0F, 4, 0, -1, 0, 2, 50, 3'b010);
        build(); run_round(0);
        // Three-cycle stall on LoadZ.
        set_round(100, 200, 300, 3'd7, 32'd1000, 1, 32'h0F0F0F0F, 4, 2, -1, 0, 5, 77, 3'b001);
        build(); run_round(0);
        // Core error on SetTimer.
        set_round(11, 22, 33, 3'd5, 32'd9, 2, 32'h12345678, 3, 0, 4, 3'b100, 1, 5, 3'b100);
        build(); run_round(0);
        // roundOver never arrives.
        set_round(1, 2, 3, 3'd3, 32'd4, 5, 32'hCAFEF00D, 2, 0, -1, 0, -1, 0, 3'b000);
        build(); run_round(0);
        // round_len = 0 behaves as 1.
        set_round(7, 8, 9, 3'd1, 32'd2, 3, 32'hA5A5A5A5, 0, 0, -1, 0, 0, 99, 3'b110);
        build(); run_round(0);
        // ready never asserted.
        set_round(7, 8, 9, 3'd1, 32'd2, 3, 32'h5A5A5A5A, 1, 3, -1, 0, 0, 1, 3'b001);
        build(); run_round(0);
        // No winner.
        set_round(5, 6, 7, 3'd6, 32'd3, 4, 32'h0BADBEEF, 3, 1, -1, 0, 3, 123, 3'b000);
        build(); run_round(0);

        // Reset asserted mid-RUN.
        set_round(1, 2, 3, 3'd7, 32'd8, 1, 32'h0F0F0F0F, 10, 0, -1, 0, 2, 9, 3'b010);
        build();
        stop_c = 0;
        for (int i = MAXC - 1; i >= 1; i--) if (e_cs[i]) stop_c = i + 3;
        run_round(stop_c);
        start = 1'b0; ready = 1'b0; err = '0; roundOver = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cstart", C_start, 0); chk("arst_busy", busy, 0); chk("arst_op", C_op, 0);
        chk("arst_done", done, 0); chk("arst_seq_err", seq_err, 0);
        m_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        set_round(100, 200, 300, 3'd7, 32'd1000, 1, 32'h0F0F0F0F, 4, 0, -1, 0, 2, 50, 3'b010);
        build(); run_round(0);

        // Randomised rounds.
        for (int k = 0; k < 10; k++) begin
            set_round($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, 16'($urandom_range(0, 6)), 1,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
                      3'($urandom_range(1, 7)), int'($urandom_range(0, 70)), $urandom,
                      3'($urandom_range(0, 7)));
            build(); run_round(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
